// File: rtl/parity2d_decoder.sv
// 2D even-parity decoder: one row per cycle. It builds the row and column syndromes, then fixes a single data-bit error or flags the error.
// Latency: done rises WIDTH+1 cycles after the accept edge. Level start/done handshake: done holds until start drops.
module parity2d_decoder #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [WIDTH-1:0][DEPTH-1:0]      data_in,
  input  logic [WIDTH-1:0]                 row_parity_in,
  input  logic [DEPTH-1:0]                 col_parity_in,
  output logic [WIDTH-1:0][DEPTH-1:0]      data_out,
  output logic                             busy,
  output logic                             done,
  output logic                             corrected,
  output logic                             parity_err,
  output logic                             uncorrectable,
  output logic [$clog2(WIDTH)-1:0]         err_row,
  output logic [$clog2(DEPTH)-1:0]         err_col
);

  localparam int RW = $clog2(WIDTH);
  localparam int CW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, CHECK, EVAL, DONE} state_t;

  state_t                        state_q, state_d;
  logic [WIDTH-1:0][DEPTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0][DEPTH-1:0]   dout_q, dout_d;
  logic [WIDTH-1:0]              rp_q, rp_d, rs_q, rs_d;
  logic [DEPTH-1:0]              cp_q, cp_d, cs_q, cs_d;
  logic [RW-1:0]                 cnt_q, cnt_d;
  logic                          done_q, done_d;
  logic                          corr_q, corr_d;
  logic                          perr_q, perr_d;
  logic                          unc_q, unc_d;
  logic [RW-1:0]                 erow_q, erow_d;
  logic [CW-1:0]                 ecol_q, ecol_d;
  logic [RW-1:0]                 rs_idx;
  logic [CW-1:0]                 cs_idx;
  logic                          rs_one, cs_one;

  // The syndrome bit positions are meaningful only when exactly one bit is set.
  always_comb begin
    rs_idx = '0;
    cs_idx = '0;
    for (int i = 0; i < WIDTH; i++) if (rs_q[i]) rs_idx = RW'(i);
    for (int j = 0; j < DEPTH; j++) if (cs_q[j]) cs_idx = CW'(j);
    rs_one = ($countones(rs_q) == 1);
    cs_one = ($countones(cs_q) == 1);
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dout_d  = dout_q;
    rp_d    = rp_q;
    cp_d    = cp_q;
    rs_d    = rs_q;
    cs_d    = cs_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    corr_d  = corr_q;
    perr_d  = perr_q;
    unc_d   = unc_q;
    erow_d  = erow_q;
    ecol_d  = ecol_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = data_in;
          rp_d    = row_parity_in;
          cp_d    = col_parity_in;
          rs_d    = '0;
          cs_d    = '0;
          cnt_d   = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        rs_d[cnt_q] = (^data_q[cnt_q]) ^ rp_q[cnt_q];
        cs_d        = cs_q ^ data_q[cnt_q];
        if (cnt_q == RW'(WIDTH - 1)) begin
          cs_d    = cs_d ^ cp_q;
          state_d = EVAL;
        end else begin
          cnt_d = cnt_q + RW'(1);
        end
      end
      EVAL: begin
        dout_d = data_q;
        corr_d = 1'b0;
        perr_d = 1'b0;
        unc_d  = 1'b0;
        erow_d = '0;
        ecol_d = '0;
        if (rs_q == '0 && cs_q == '0) begin
          corr_d = 1'b0;
        end else if (rs_one && cs_one) begin
          dout_d[rs_idx][cs_idx] = ~data_q[rs_idx][cs_idx];
          corr_d = 1'b1;
          erow_d = rs_idx;
          ecol_d = cs_idx;
        end else if ((rs_one && cs_q == '0) || (cs_one && rs_q == '0)) begin
          perr_d = 1'b1;
        end else begin
          unc_d = 1'b1;
        end
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      dout_q  <= '0;
      rp_q    <= '0;
      cp_q    <= '0;
      rs_q    <= '0;
      cs_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      corr_q  <= 1'b0;
      perr_q  <= 1'b0;
      unc_q   <= 1'b0;
      erow_q  <= '0;
      ecol_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dout_q  <= dout_d;
      rp_q    <= rp_d;
      cp_q    <= cp_d;
      rs_q    <= rs_d;
      cs_q    <= cs_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      corr_q  <= corr_d;
      perr_q  <= perr_d;
      unc_q   <= unc_d;
      erow_q  <= erow_d;
      ecol_q  <= ecol_d;
    end
  end

  assign busy          = (state_q == CHECK) || (state_q == EVAL);
  assign done          = done_q;
  assign data_out      = dout_q;
  assign corrected     = corr_q;
  assign parity_err    = perr_q;
  assign uncorrectable = unc_q;
  assign err_row       = erow_q;
  assign err_col       = ecol_q;

endmodule

// File: tb/tb_parity2d_decoder.sv
// Directed and random decodes of parity2d_decoder, checked against a whole-matrix parity reference model.
module tb_parity2d_decoder;
  localparam int W = 4;
  localparam int D = 4;

  typedef logic [W-1:0][D-1:0] mat_t;

  logic clk = 1'b0;
  logic rst_n, start;
  mat_t data_in, data_out;
  logic [W-1:0] row_parity_in;
  logic [D-1:0] col_parity_in;
  logic busy, done, corrected, parity_err, uncorrectable;
  logic [1:0] err_row, err_col;

  int n_chk = 0;
  int n_fail = 0;

  // Expected results from the most recent model evaluation.
  mat_t     exp_data;
  logic     exp_corr, exp_perr, exp_unc;
  int       exp_r, exp_c;

  parity2d_decoder #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
    .row_parity_in(row_parity_in), .col_parity_in(col_parity_in),
    .data_out(data_out), .busy(busy), .done(done), .corrected(corrected),
    .parity_err(parity_err), .uncorrectable(uncorrectable),
    .err_row(err_row), .err_col(err_col)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: count mismatching rows and columns of the whole matrix, then classify.
  task automatic model(input mat_t d, input logic [W-1:0] rp, input logic [D-1:0] cp);
    int bad_rows[$];
    int bad_cols[$];
    for (int r = 0; r < W; r++) begin
      int ones = 0;
      for (int c = 0; c < D; c++) ones += int'(d[r][c]);
      if ((ones % 2) != int'(rp[r])) bad_rows.push_back(r);
    end
    for (int c = 0; c < D; c++) begin
      int ones = 0;
      for (int r = 0; r < W; r++) ones += int'(d[r][c]);
      if ((ones % 2) != int'(cp[c])) bad_cols.push_back(c);
    end
    exp_data = d;
    exp_corr = 1'b0; exp_perr = 1'b0; exp_unc = 1'b0;
    exp_r = 0; exp_c = 0;
    if (bad_rows.size() == 0 && bad_cols.size() == 0) begin
      exp_corr = 1'b0;
    end else if (bad_rows.size() == 1 && bad_cols.size() == 1) begin
      exp_corr = 1'b1;
      exp_r = bad_rows[0];
      exp_c = bad_cols[0];
      exp_data[exp_r][exp_c] = ~d[exp_r][exp_c];
    end else if (bad_rows.size() + bad_cols.size() == 1) begin
      exp_perr = 1'b1;
    end else begin
      exp_unc = 1'b1;
    end
  endtask

  task automatic chk_result(input string tag);
    chk({tag, ".data"}, 32'(data_out), 32'(exp_data));
    chk({tag, ".corr"}, 32'(corrected), 32'(exp_corr));
    chk({tag, ".perr"}, 32'(parity_err), 32'(exp_perr));
    chk({tag, ".unc"}, 32'(uncorrectable), 32'(exp_unc));
    chk({tag, ".erow"}, 32'(err_row), 32'(exp_r));
    chk({tag, ".ecol"}, 32'(err_col), 32'(exp_c));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full decode. drop_early releases start right after the accept edge;
  // otherwise start stays high for `hold` cycles past done before being dropped.
  task automatic decode(input string tag, input mat_t d, input logic [W-1:0] rp,
                        input logic [D-1:0] cp, input bit drop_early, input int hold);
    model(d, rp, cp);
    data_in = d; row_parity_in = rp; col_parity_in = cp; start = 1'b1;
    tick();
    chk({tag, ".busy_acc"}, 32'(busy), 32'd1);
    data_in = mat_t'($urandom);
    row_parity_in = W'($urandom);
    col_parity_in = D'($urandom);
    if (drop_early) start = 1'b0;
    for (int i = 0; i < W; i++) begin
      tick();
      chk({tag, ".done_early"}, 32'(done), 32'd0);
      chk({tag, ".busy_run"}, 32'(busy), 32'd1);
    end
    tick();
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".busy_done"}, 32'(busy), 32'd0);
    chk_result(tag);
    if (!drop_early) begin
      for (int i = 0; i < hold; i++) begin
        tick();
        chk({tag, ".done_hold"}, 32'(done), 32'd1);
        chk({tag, ".busy_hold"}, 32'(busy), 32'd0);
      end
      start = 1'b0;
    end
    tick();
    chk({tag, ".done_fall"}, 32'(done), 32'd0);
    chk_result({tag, ".kept"});
  endtask

  mat_t clean, m;
  logic [W-1:0] rp_clean, rpv;
  logic [D-1:0] cp_clean, cpv;

  initial begin
    rst_n = 1'b0; start = 1'b0;
    data_in = '0; row_parity_in = '0; col_parity_in = '0;
    tick(); tick();
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.data", 32'(data_out), 32'd0);
    chk("rst.flags", {29'd0, corrected, parity_err, uncorrectable}, 32'd0);
    chk("rst.pos", {28'd0, err_row, err_col}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Row r holds a single 1 in column r, so every row and column parity is 1.
    clean = '0;
    clean[0] = 4'h1; clean[1] = 4'h2; clean[2] = 4'h4; clean[3] = 4'h8;
    rp_clean = 4'b1111;
    cp_clean = 4'b1111;

    decode("clean", clean, rp_clean, cp_clean, 1'b1, 0);
    chk("clean.flags_abs", {29'd0, corrected, parity_err, uncorrectable}, 32'd0);

    m = clean; m[2] = 4'h6;
    decode("single", m, rp_clean, cp_clean, 1'b1, 0);
    chk("single.corr_abs", 32'(corrected), 32'd1);
    chk("single.erow_abs", 32'(err_row), 32'd2);
    chk("single.ecol_abs", 32'(err_col), 32'd1);
    chk("single.row2_abs", 32'(data_out[2]), 32'h4);

    decode("par_only", clean, 4'b1110, cp_clean, 1'b1, 0);
    chk("par_only.abs", {29'd0, corrected, parity_err, uncorrectable}, 32'b010);
    chk("par_only.data_abs", 32'(data_out), 32'(clean));

    m = clean; m[0] = clean[0] ^ 4'b0011;
    decode("double", m, rp_clean, cp_clean, 1'b1, 0);
    chk("double.unc_abs", {29'd0, corrected, parity_err, uncorrectable}, 32'b001);
    chk("double.data_abs", 32'(data_out), 32'(m));

    // Reset asserted for the edge that ends the second CHECK cycle.
    data_in = clean; row_parity_in = rp_clean; col_parity_in = cp_clean; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.done", 32'(done), 32'd0);
    chk("midrst.data", 32'(data_out), 32'd0);
    chk("midrst.flags", {29'd0, corrected, parity_err, uncorrectable}, 32'd0);
    for (int i = 0; i < W + 2; i++) begin
      tick();
      chk("midrst.no_result", 32'(done), 32'd0);
    end
    decode("post_rst", clean, rp_clean, cp_clean, 1'b1, 0);

    // Start held past done must not retrigger; a fresh assertion does.
    m = clean; m[1] = clean[1] ^ 4'b1000;
    decode("hold", m, rp_clean, cp_clean, 1'b0, 3);
    decode("reassert", clean, rp_clean, 4'b0111, 1'b0, 1);

    for (int t = 0; t < 24; t++) begin
      m = mat_t'($urandom);
      rpv = '0; cpv = '0;
      for (int r = 0; r < W; r++) rpv[r] = ^m[r];
      for (int c = 0; c < D; c++)
        for (int r = 0; r < W; r++) cpv[c] = cpv[c] ^ m[r][c];
      case ($urandom_range(0, 4))
        0: ;
        1: m[$urandom_range(0, W-1)][$urandom_range(0, D-1)] ^= 1'b1;
        2: rpv[$urandom_range(0, W-1)] ^= 1'b1;
        3: cpv[$urandom_range(0, D-1)] ^= 1'b1;
        default: begin
          m = m ^ mat_t'($urandom);
          rpv = rpv ^ W'($urandom);
        end
      endcase
      decode("rand", m, rpv, cpv, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
